// File: rtl/qsys_system_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into 30-bit DCT words (valid/ready output) and
// sequences end-of-test draining via a RUN/DRAIN/ENDED state machine.
module qsys_system_nios2_qsys_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        flush,
  input  logic        stop_req,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended,
  output logic [1:0]  dbg_state
);

  // Handshakes: an atom moves when atom_valid && atom_ready at the rising edge;
  // a word moves when dct_valid && dct_ready at the rising edge. A held word
  // (dct_valid && !dct_ready) keeps dct_buffer/dct_count stable.

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_ENDED = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [29:0] acc_buf, acc_buf_d;
  logic [3:0]  acc_cnt, acc_cnt_d;
  logic [7:0]  idle_cnt;
  logic        accept, out_free, timeout, emit, xfer;
  logic [31:0] keep_mask;

  assign out_free  = !dct_valid || dct_ready;
  assign timeout   = (idle_cnt == 8'(FLUSH_TIMEOUT));
  assign emit      = (acc_cnt == 4'd15) ||
                     ((acc_cnt != 4'd0) && (flush || timeout || state == S_DRAIN));
  assign xfer      = emit && out_free;
  assign atom_ready = (state == S_RUN) && ((acc_cnt != 4'd15) || xfer);
  assign accept    = atom_valid && atom_ready;
  assign keep_mask = (32'd1 << {acc_cnt, 1'b0}) - 32'd1;

  assign test_ending    = (state != S_RUN);
  assign test_has_ended = (state == S_ENDED);
  assign dbg_state      = state;

  always_comb begin
    state_d = state;
    case (state)
      S_RUN:   if (stop_req) state_d = S_DRAIN;
      S_DRAIN: if ((acc_cnt == 4'd0) && out_free) state_d = S_ENDED;
      S_ENDED: state_d = S_ENDED;
      default: state_d = S_RUN;
    endcase
  end

  // An atom arriving on a transfer cycle lands in slot 0 of the emptied word.
  always_comb begin
    acc_buf_d = acc_buf;
    acc_cnt_d = acc_cnt;
    if (xfer) begin
      acc_buf_d = '0;
      acc_cnt_d = 4'd0;
      if (accept) begin
        acc_buf_d[1:0] = atom_data;
        acc_cnt_d      = 4'd1;
      end
    end else if (accept) begin
      acc_buf_d[{acc_cnt, 1'b0} +: 2] = atom_data;
      acc_cnt_d = acc_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_RUN;
      acc_buf    <= '0;
      acc_cnt    <= '0;
      idle_cnt   <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else begin
      state   <= state_d;
      acc_buf <= acc_buf_d;
      acc_cnt <= acc_cnt_d;
      // Holding at the threshold keeps a timeout pending through backpressure.
      if (accept || xfer)
        idle_cnt <= '0;
      else if ((acc_cnt != 4'd0) && !timeout && (idle_cnt != 8'hFF))
        idle_cnt <= idle_cnt + 8'd1;
      if (xfer) begin
        dct_buffer <= acc_buf & keep_mask[29:0];
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
      end else if (dct_valid && dct_ready) begin
        dct_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qsys_system_nios2_qsys_oci_dct_packer.sv
// Bench for the DCT packer: table-driven word vectors, hand-written corner
// sequences and a random phase, all checked through an expected-word queue.
module tb_qsys_system_nios2_qsys_oci_dct_packer;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic        stop_req = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        test_ending;
  logic        test_has_ended;
  logic [1:0]  dbg_state;

  qsys_system_nios2_qsys_oci_dct_packer #(.FLUSH_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush(flush), .stop_req(stop_req),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int ready_stalls = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  typedef struct {
    int          n;
    int          mode;
    logic [3:0]  cnt;
    logic [29:0] buf_v;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] atom_of(input int mode, input int i);
    case (mode)
      0: atom_of = 2'(i % 4);
      1: atom_of = 2'd3;
      2: atom_of = 2'(3 - (i % 4));
      default: atom_of = (i % 2 == 0) ? 2'd1 : 2'd2;
    endcase
  endfunction

  // scoreboard: pop one expected word per output handshake
  always @(negedge clk) begin
    if (reset_n && dct_valid && dct_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", {dct_count, dct_buffer});
      end else begin
        mon_exp = exp_q.pop_front();
        check("word", 64'({dct_count, dct_buffer}), 64'(mon_exp));
      end
    end
  end

  // driver tasks: all start and end at posedge + 1
  task automatic send_atom(input logic [1:0] d);
    int waited = 0;
    atom_valid = 1'b1;
    atom_data  = d;
    @(negedge clk);
    while (!atom_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited != 0) ready_stalls++;
    if (!atom_ready) check("atom_accept_timeout", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;
    atom_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input bit rand_rdy);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) dct_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    atom_valid = 1'b0;
    flush = 1'b0;
    stop_req = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_buffer"}, 64'(dct_buffer), 64'd0);
    check({tag, "_count"}, 64'(dct_count), 64'd0);
    check({tag, "_valid"}, 64'(dct_valid), 64'd0);
    check({tag, "_ending"}, 64'(test_ending), 64'd0);
    check({tag, "_ended"}, 64'(test_has_ended), 64'd0);
  endtask

  initial begin
    logic [29:0] eb;
    int n, k;

    vecs[0] = '{15, 0, 4'd15, 30'h24E4E4E4};
    vecs[1] = '{5,  1, 4'd5,  30'h000003FF};
    vecs[2] = '{1,  1, 4'd1,  30'h00000003};
    vecs[3] = '{7,  2, 4'd7,  30'h00001B1B};
    vecs[4] = '{15, 2, 4'd15, 30'h1B1B1B1B};
    vecs[5] = '{10, 3, 4'd10, 30'h00099999};
    vecs[6] = '{14, 0, 4'd14, 30'h04E4E4E4};

    // reset state
    #12;
    check_idle_outputs("in_reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");
    check("after_reset_atom_ready", 64'(atom_ready), 64'd1);

    // table vectors, consumer always ready
    dct_ready = 1'b1;
    foreach (vecs[v]) begin
      exp_q.push_back({vecs[v].cnt, vecs[v].buf_v});
      for (int i = 0; i < vecs[v].n; i++) send_atom(atom_of(vecs[v].mode, i));
      if (vecs[v].n == 15) begin
        check("full_not_yet_valid", 64'(dct_valid), 64'd0);
        @(posedge clk); #1;
        check("full_valid_latency", 64'(dct_valid), 64'd1);
      end else begin
        pulse_flush();
        check("flush_valid_latency", 64'(dct_valid), 64'd1);
      end
      wait_empty(50, 1'b0);
    end
    check("no_ready_stall", 64'(ready_stalls), 64'd0);

    // flush together with an atom: atom starts the next word
    for (int i = 0; i < 4; i++) send_atom(2'd2);
    exp_q.push_back({4'd4, 30'h000000AA});
    exp_q.push_back({4'd1, 30'h00000001});
    atom_valid = 1'b1; atom_data = 2'd1; flush = 1'b1;
    @(negedge clk);
    check("flush_atom_ready", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;
    atom_valid = 1'b0; flush = 1'b0;
    check("flush_atom_count", 64'(dct_count), 64'd4);
    @(posedge clk); #1;
    pulse_flush();
    wait_empty(20, 1'b0);

    // timeout after the last accept
    exp_q.push_back({4'd3, 30'h00000033});
    send_atom(2'd3); send_atom(2'd0); send_atom(2'd3);
    k = 0;
    while (!dct_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout_latency", 64'(k), 64'(TO + 1));
    wait_empty(20, 1'b0);

    // backpressure: 30 atoms absorbed, 31st held off
    dct_ready = 1'b0;
    exp_q.push_back({4'd15, 30'h24E4E4E4});
    exp_q.push_back({4'd15, 30'h13939393});
    exp_q.push_back({4'd1,  30'h00000002});
    for (int i = 0; i < 30; i++) send_atom(atom_of(0, i));
    atom_valid = 1'b1; atom_data = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_atom_ready_low", 64'(atom_ready), 64'd0);
      check("bp_buffer_stable", 64'(dct_buffer), 64'h24E4E4E4);
    end
    @(posedge clk); #1;
    dct_ready = 1'b1;
    @(negedge clk);
    check("bp_release_accept", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;
    atom_valid = 1'b0;
    @(posedge clk); #1;
    pulse_flush();
    wait_empty(20, 1'b0);

    // random packets closed by timeout, random consumer stalls
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 15);
      eb = '0;
      for (int i = 0; i < n; i++) eb[2*i +: 2] = 2'($urandom_range(0, 3));
      exp_q.push_back({4'(n), eb});
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          dct_ready = $urandom_range(0, 1);
        end
        send_atom(eb[2*i +: 2]);
      end
      wait_empty(300, 1'b1);
    end
    dct_ready = 1'b1;
    @(posedge clk); #1;

    // end of test: one held word, one partial, atom offered with stop_req
    dct_ready = 1'b0;
    exp_q.push_back({4'd4, 30'h00000055});
    exp_q.push_back({4'd3, 30'h0000002A});
    for (int i = 0; i < 4; i++) send_atom(2'd1);
    pulse_flush();
    send_atom(2'd2); send_atom(2'd2);
    atom_valid = 1'b1; atom_data = 2'd2; stop_req = 1'b1;
    @(negedge clk);
    check("stop_cycle_atom_ready", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;
    atom_valid = 1'b0; stop_req = 1'b0;
    check("stop_test_ending", 64'(test_ending), 64'd1);
    check("stop_atom_ready", 64'(atom_ready), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("drain_not_ended", 64'(test_has_ended), 64'd0);
    dct_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_second_word", 64'({dct_valid, dct_count}), 64'h13);
    check("drain_not_ended_yet", 64'(test_has_ended), 64'd0);
    @(posedge clk); #1;
    check("ended_after_handshake", 64'(test_has_ended), 64'd1);
    check("ended_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("ended_sticky", 64'({test_ending, test_has_ended, atom_ready}), 64'h6);

    // reset in the middle of a drain discards everything
    do_reset();
    dct_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_atom(2'd3);
    pulse_flush();
    send_atom(2'd1); send_atom(2'd1);
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    check("middrain_ending", 64'(test_ending), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("middrain_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    dct_ready = 1'b1;
    @(posedge clk); #1;

    // stop with nothing pending ends one edge after DRAIN entry
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    check("empty_stop_ending", 64'({test_ending, test_has_ended}), 64'h2);
    @(posedge clk); #1;
    check("empty_stop_ended", 64'({test_has_ended, atom_ready}), 64'h2);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
